// File: rtl/reg_rd_pkg.sv
// ============================================================================
// Module   : reg_rd_pkg
// Brief    : Shared widths and response-entry type for the register read unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_rd_pkg;
  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int TW   = 3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
  } rd_entry_t;
endpackage

`default_nettype wire

// File: rtl/rsp_fifo2.sv
// ============================================================================
// Module   : rsp_fifo2
// Brief    : Two-entry response buffer with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rsp_fifo2
  import reg_rd_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  output logic      push_ready,
  input  rd_entry_t push_data,
  output logic      pop_valid,
  input  logic      pop_ready,
  output rd_entry_t pop_data
);

  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  rd_entry_t  r_mem [2];
  logic       w_push;
  logic       w_pop;

  // Readiness depends only on count, so a pop cannot free a slot for a same-cycle push.
  assign push_ready = (r_count != 2'd2);
  assign pop_valid  = (r_count != 2'd0);
  assign pop_data   = r_mem[r_rd_ptr];
  assign w_push     = push_valid && push_ready;
  assign w_pop      = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_read_unit.sv
// ============================================================================
// Module   : reg_read_unit
// Brief    : Register-file read side: operand select, optional write-back
//            bypass (REG_RD_BYPASS_EN), 2-entry response buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_read_unit
  import reg_rd_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_sa,
  input  logic [AW-1:0] req_sb,
  input  logic [TW-1:0] req_tag,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [DW-1:0] r3,
  input  logic [DW-1:0] r4,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_sel,
  input  logic [DW-1:0] wb_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic [TW-1:0] rsp_tag
);

  logic [DW-1:0] w_regs [NREG];
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;
  rd_entry_t     w_push_data;
  rd_entry_t     w_head;

  assign w_regs[0] = r1;
  assign w_regs[1] = r2;
  assign w_regs[2] = r3;
  assign w_regs[3] = r4;

`ifdef REG_RD_BYPASS_EN
  // A register being written this cycle supplies its new value to the operand.
  always_comb begin
    w_op_a = w_regs[req_sa];
    w_op_b = w_regs[req_sb];
    if (wb_valid && (wb_sel == req_sa)) w_op_a = wb_data;
    if (wb_valid && (wb_sel == req_sb)) w_op_b = wb_data;
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_sel, wb_data};
  assign w_op_a      = w_regs[req_sa];
  assign w_op_b      = w_regs[req_sb];
`endif

  assign w_push_data = '{a: w_op_a, b: w_op_b, tag: req_tag};

  rsp_fifo2 u_rsp_fifo2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (req_valid),
    .push_ready (req_ready),
    .push_data  (w_push_data),
    .pop_valid  (rsp_valid),
    .pop_ready  (rsp_ready),
    .pop_data   (w_head)
  );

  assign rsp_a   = w_head.a;
  assign rsp_b   = w_head.b;
  assign rsp_tag = w_head.tag;

endmodule

`default_nettype wire

// File: tb/tb_reg_read_unit.sv
// ============================================================================
// Module   : tb_reg_read_unit
// Brief    : Self-checking bench for reg_read_unit (honours REG_RD_BYPASS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_read_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sa = '0;
  logic [1:0] req_sb = '0;
  logic [2:0] req_tag = '0;
  logic [7:0] regs [4];
  logic       wb_valid = 1'b0;
  logic [1:0] wb_sel = '0;
  logic [7:0] wb_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_a;
  logic [7:0] rsp_b;
  logic [2:0] rsp_tag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] tag;
  } exp_t;

  exp_t model_q [$];

  typedef struct {
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] tag;
    logic [7:0] r [4];
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  always #5 clk = ~clk;

  reg_read_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sa    (req_sa),
    .req_sb    (req_sb),
    .req_tag   (req_tag),
    .r1        (regs[0]),
    .r2        (regs[1]),
    .r3        (regs[2]),
    .r4        (regs[3]),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rsp_tag   (rsp_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] operand(input logic [1:0] sel);
    logic [7:0] v;
    v = regs[sel];
`ifdef REG_RD_BYPASS_EN
    if (wb_valid && wb_sel == sel) v = wb_data;
`endif
    return v;
  endfunction

  task automatic compare_model();
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, model_q.size() != 0});
    check("req_ready", {31'd0, req_ready}, {31'd0, model_q.size() != 2});
    if (model_q.size() != 0) begin
      check("rsp_a", {24'd0, rsp_a}, {24'd0, model_q[0].a});
      check("rsp_b", {24'd0, rsp_b}, {24'd0, model_q[0].b});
      check("rsp_tag", {29'd0, rsp_tag}, {29'd0, model_q[0].tag});
    end
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    bit   acc;
    bit   pop;
    exp_t e;
    acc   = req_valid && (model_q.size() < 2);
    pop   = (model_q.size() > 0) && rsp_ready;
    e.a   = operand(req_sa);
    e.b   = operand(req_sb);
    e.tag = req_tag;
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back(e);
    compare_model();
  endtask

  task automatic drive_req(input logic v, input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] tag);
    req_valid = v;
    req_sa    = sa;
    req_sb    = sb;
    req_tag   = tag;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4 && model_q.size() != 0; i++) tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs [4];
    logic [7:0] held_a;

    vecs[0] = '{sa: 2'd2, sb: 2'd0, tag: 3'd5, r: '{8'h11, 8'h22, 8'h33, 8'h44}, exp_a: 8'h33, exp_b: 8'h11};
    vecs[1] = '{sa: 2'd3, sb: 2'd3, tag: 3'd1, r: '{8'h11, 8'h22, 8'h33, 8'h44}, exp_a: 8'h44, exp_b: 8'h44};
    vecs[2] = '{sa: 2'd1, sb: 2'd2, tag: 3'd7, r: '{8'hA0, 8'hB1, 8'hC2, 8'hD3}, exp_a: 8'hB1, exp_b: 8'hC2};
    vecs[3] = '{sa: 2'd0, sb: 2'd3, tag: 3'd0, r: '{8'hFF, 8'h00, 8'h5A, 8'h01}, exp_a: 8'hFF, exp_b: 8'h01};

    for (int i = 0; i < 4; i++) regs[i] = '0;

    // Reset state
    #12;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_a", {24'd0, rsp_a}, 32'd0);
    check("reset_rsp_tag", {29'd0, rsp_tag}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single reads into an empty buffer
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) regs[k] = vecs[i].r[k];
      drive_req(1'b1, vecs[i].sa, vecs[i].sb, vecs[i].tag);
      tick();
      req_valid = 1'b0;
      check("vec_valid", {31'd0, rsp_valid}, 32'd1);
      check("vec_a", {24'd0, rsp_a}, {24'd0, vecs[i].exp_a});
      check("vec_b", {24'd0, rsp_b}, {24'd0, vecs[i].exp_b});
      check("vec_tag", {29'd0, rsp_tag}, {29'd0, vecs[i].tag});
      drain();
    end

    // Backpressure: third request stalls until the consumer drains
    regs = '{8'h11, 8'h22, 8'h33, 8'h44};
    rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive_req(1'b1, 2'(t), 2'(t + 1), 3'(t));
      if (t < 2) tick();
    end
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    regs[2] = 8'h99;
    tick();
    check("bp_stall_head", {29'd0, rsp_tag}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("bp_pop0_head", {29'd0, rsp_tag}, 32'd1);
    tick();
    check("bp_third_head", {29'd0, rsp_tag}, 32'd2);
    check("bp_third_a", {24'd0, rsp_a}, 32'h99);
    drain();

    // Streaming: one response per cycle, buffer never fills
    rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drive_req(1'b1, 2'(t), 2'(t + 3), 3'(t));
      tick();
      check("stream_tag", {29'd0, rsp_tag}, t);
      check("stream_not_full", {31'd0, req_ready}, 32'd1);
    end
    drain();

    // Write-back bypass on both operands
    regs = '{8'h11, 8'h22, 8'h33, 8'h44};
    wb_valid = 1'b1;
    wb_sel   = 2'd1;
    wb_data  = 8'hA5;
    drive_req(1'b1, 2'd1, 2'd1, 3'd3);
    tick();
    req_valid = 1'b0;
    wb_valid  = 1'b0;
`ifdef REG_RD_BYPASS_EN
    check("bypass_a", {24'd0, rsp_a}, 32'hA5);
    check("bypass_b", {24'd0, rsp_b}, 32'hA5);
`else
    check("nobypass_a", {24'd0, rsp_a}, 32'h22);
    check("nobypass_b", {24'd0, rsp_b}, 32'h22);
`endif

    // Head holds while stalled and registers change
    rsp_ready = 1'b0;
    held_a = model_q[0].a;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) regs[k] = 8'($urandom);
      tick();
      check("hold_a", {24'd0, rsp_a}, {24'd0, held_a});
      check("hold_tag", {29'd0, rsp_tag}, 32'd3);
    end
    drain();

    // Asynchronous reset with two entries buffered
    drive_req(1'b1, 2'd2, 2'd3, 3'd6);
    tick();
    tick();
    req_valid = 1'b0;
    check("pre_reset_full", {31'd0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check("midreset_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_ready", {31'd0, req_ready}, 32'd1);
    check("midreset_a", {24'd0, rsp_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_model();

    // Randomized traffic against the queue model
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 4; k++) regs[k] = 8'($urandom);
      drive_req(1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom));
      rsp_ready = 1'($urandom);
      wb_valid  = 1'($urandom);
      wb_sel    = 2'($urandom);
      wb_data   = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
